// File: rtl/mem_arbiter.sv
// Two-requester cache-line memory arbiter (dcache = m0, icache = m1).
// Round-robin grant, one outstanding memory transaction at a time.
// Optional BUSY watchdog: define MEM_ARB_TIMEOUT_EN to enable it; without the
// macro BUSY waits for mem_ack_i indefinitely and err_o stays low.
//
// state | meaning
// IDLE  | waiting for a request; captures the winner's transaction on grant
// BUSY  | mem_enable_o high with the captured request held until mem_ack_i
// RESP  | one-cycle completion pulse to the owner (err_o set on timeout)
module mem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 256,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_enable_i,
   input  logic              m0_write_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_data_o,
   input  logic              m1_enable_i,
   input  logic              m1_write_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              err_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0] state;
   logic       owner;       // 0 = m0, 1 = m1
   logic       last_grant;  // requester granted most recently; resets to m1 so m0 wins the first tie
   logic       grant_m1;
   logic       timeout_hit;
   logic       err_q;

   // m1 wins when it is the only requester, or on a tie when m0 was granted last
   assign grant_m1 = m1_enable_i & (~m0_enable_i | ~last_grant);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] busy_cnt;

   // Counts cycles spent in BUSY; held at zero everywhere else
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         busy_cnt <= '0;
      else if (state != ST_BUSY)
         busy_cnt <= '0;
      else
         busy_cnt <= busy_cnt + 1'b1;
   end

   // Fires on the last permitted BUSY cycle so BUSY lasts exactly TIMEOUT_CYCLES
   assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog absent: the limit parameter has no effect and never fires
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Arbitration, transaction capture, read-data return and sequencing
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= ST_IDLE;
         owner       <= 1'b0;
         last_grant  <= 1'b1;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         m0_data_o   <= '0;
         m1_data_o   <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m0_enable_i || m1_enable_i) begin
                  owner       <= grant_m1;
                  last_grant  <= grant_m1;
                  mem_write_o <= grant_m1 ? m1_write_i : m0_write_i;
                  mem_addr_o  <= grant_m1 ? m1_addr_i  : m0_addr_i;
                  mem_data_o  <= grant_m1 ? m1_data_i  : m0_data_i;
                  state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack_i) begin
                  if (!mem_write_o) begin
                     if (owner)
                        m1_data_o <= mem_data_i;
                     else
                        m0_data_o <= mem_data_i;
                  end
                  state <= ST_RESP;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               err_q <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_enable_o = (state == ST_BUSY);
   assign m0_ack_o     = (state == ST_RESP) & ~owner;
   assign m1_ack_o     = (state == ST_RESP) &  owner;
   assign err_o        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level reference model
// predicts grants, memory requests and completions; a negedge monitor pops
// and compares whenever the DUT presents a memory request or an ack.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 256;
   localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i, mem_addr_o;
   logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, mem_data_o;
   logic [DW-1:0] mem_data_i = '0;
   logic m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, err_o;
   logic mem_ack_i = 1'b0;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .err_o(err_o));

   typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} mreq_t;
   typedef struct packed {logic owner; logic err; logic [DW-1:0] data;} resp_t;

   mreq_t mem_q[$];
   resp_t resp_q[$];
   int    ack_order[$];
   int    n_checks = 0, n_fail = 0;

   // requester stimulus
   bit            rq_en[2], rq_wr[2];
   logic [AW-1:0] rq_addr[2];
   logic [DW-1:0] rq_data[2];
   bit            outst[2], done_flag[2];
   assign m0_enable_i = rq_en[0];
   assign m0_write_i  = rq_wr[0];
   assign m0_addr_i   = rq_addr[0];
   assign m0_data_i   = rq_data[0];
   assign m1_enable_i = rq_en[1];
   assign m1_write_i  = rq_wr[1];
   assign m1_addr_i   = rq_addr[1];
   assign m1_data_i   = rq_data[1];

   // reference model
   bit            m_busy, m_resp, m_owner, lg, cur_wr;
   int            busy_cycles, mem_wait;
   logic [DW-1:0] d[2];

   // stimulus controls
   bit            auto_req = 0, spur_en = 0, drop_en = 0, force_rd_valid = 0;
   int            force_delay = -1;
   logic [DW-1:0] force_rd = '0;

   // monitor observations
   int ack_cnt[2];
   int err_cnt = 0, en_cycles = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_resp = 0; lg = 1; busy_cycles = 0; mem_wait = 0;
      d[0] = '0; d[1] = '0;
      mem_q.delete(); resp_q.delete();
      for (int i = 0; i < 2; i++) begin
         outst[i] = 0; done_flag[i] = 0; rq_en[i] = 0;
      end
      mem_ack_i = 0;
   endtask

   task automatic finish_txn(input bit err);
      m_busy = 0; m_resp = 1;
      resp_q.push_back('{owner: m_owner, err: err, data: d[m_owner]});
   endtask

   // What the arbiter must do at the clock edge that just happened
   task automatic model_edge();
      bit w;
      if (!rst_i) return;
      if (m_resp) begin
         m_resp = 0;
         done_flag[m_owner] = 1;
      end else if (m_busy) begin
         busy_cycles++;
         if (mem_ack_i) begin
            if (!cur_wr) d[m_owner] = mem_data_i;
            finish_txn(0);
         end else if (TO_ON && busy_cycles == TO) begin
            finish_txn(1);
         end
      end else if (rq_en[0] || rq_en[1]) begin
         // tie goes to whoever was not granted last; lone requester always wins
         w = (rq_en[0] && rq_en[1]) ? !lg : rq_en[1];
         m_owner = w; lg = w; m_busy = 1; busy_cycles = 0; cur_wr = rq_wr[w];
         mem_q.push_back('{wr: rq_wr[w], addr: rq_addr[w], data: rq_data[w]});
         if (force_delay >= 0) mem_wait = force_delay;
         else if (TO_ON && $urandom_range(0, 7) == 0) mem_wait = 1000;
         else mem_wait = $urandom_range(0, 5);
      end
   endtask

   task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] dt);
      rq_en[i] = 1; rq_wr[i] = wr; rq_addr[i] = a; rq_data[i] = dt; outst[i] = 1;
   endtask

   task automatic drive_next();
      if (!rst_i) begin
         rq_en[0] = 0; rq_en[1] = 0; mem_ack_i = 0;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         if (done_flag[i]) begin
            done_flag[i] = 0; rq_en[i] = 0; outst[i] = 0;
         end else if (outst[i] && rq_en[i] && drop_en && m_busy && m_owner == i[0]
                      && $urandom_range(0, 7) == 0) begin
            rq_en[i] = 0;
         end else if (!outst[i] && auto_req && $urandom_range(0, 2) == 0) begin
            issue(i, $urandom_range(0, 1) == 1, $urandom(), rnd());
         end
      end
      if (m_busy) begin
         if (mem_wait == 0) begin
            mem_ack_i = 1;
            mem_data_i = force_rd_valid ? force_rd : rnd();
         end else begin
            mem_ack_i = 0; mem_data_i = rnd(); mem_wait--;
         end
      end else begin
         mem_ack_i = spur_en && $urandom_range(0, 3) == 0;
         mem_data_i = rnd();
      end
   endtask

   task automatic step();
      @(posedge clk_i); #1;
      model_edge();
      drive_next();
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((outst[0] || outst[1] || m_busy || m_resp) && n < budget) begin
         step(); n++;
      end
      n_checks++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, " mem_enable"}, DW'(mem_enable_o), '0);
      check({name, " mem_write"},  DW'(mem_write_o),  '0);
      check({name, " mem_addr"},   DW'(mem_addr_o),   '0);
      check({name, " mem_data"},   mem_data_o,        '0);
      check({name, " m0_ack"},     DW'(m0_ack_o),     '0);
      check({name, " m1_ack"},     DW'(m1_ack_o),     '0);
      check({name, " m0_data"},    m0_data_o,         '0);
      check({name, " m1_data"},    m1_data_o,         '0);
      check({name, " err"},        DW'(err_o),        '0);
   endtask

   task automatic do_reset(input int cycles);
      rst_i = 0;
      model_reset();
      #1;
      check_zero("reset");
      repeat (cycles) step();
      rst_i = 1;
   endtask

   // Monitor: pops expected memory requests and completions as the DUT shows them
   mreq_t cur_exp;
   bit    prev_en = 0;
   always @(negedge clk_i) begin
      resp_t r;
      if (!rst_i) begin
         prev_en = 0;
      end else begin
         check("mem_enable", DW'(mem_enable_o), DW'(m_busy));
         if (mem_enable_o) en_cycles++;
         if (mem_enable_o && !prev_en && mem_q.size() > 0) cur_exp = mem_q.pop_front();
         if (mem_enable_o) begin
            check("mem_write", DW'(mem_write_o), DW'(cur_exp.wr));
            check("mem_addr",  DW'(mem_addr_o),  DW'(cur_exp.addr));
            check("mem_data",  mem_data_o,       cur_exp.data);
         end
         prev_en = mem_enable_o;
         if (m0_ack_o || m1_ack_o) begin
            ack_order.push_back(m1_ack_o ? 1 : 0);
            if (m0_ack_o) ack_cnt[0]++;
            if (m1_ack_o) ack_cnt[1]++;
            if (err_o) err_cnt++;
         end
         if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            check("ack owner", DW'({m1_ack_o, m0_ack_o}), r.owner ? DW'(2) : DW'(1));
            check("ack err", DW'(err_o), DW'(r.err));
            check("ack data", r.owner ? m1_data_o : m0_data_o, r.data);
         end else begin
            check("no ack", DW'({m1_ack_o, m0_ack_o, err_o}), '0);
         end
         check("m0_data", m0_data_o, d[0]);
         check("m1_data", m1_data_o, d[1]);
      end
   end

   initial begin
      int a0;
      logic [DW-1:0] keep;
      ack_cnt[0] = 0; ack_cnt[1] = 0;
      for (int i = 0; i < 2; i++) begin
         rq_wr[i] = 0; rq_addr[i] = '0; rq_data[i] = '0;
      end
      #2;
      do_reset(3);

      // single m0 read, memory answers after a long wait with 0x5
      force_delay = 10; force_rd_valid = 1; force_rd = DW'(5);
      issue(0, 0, '0, rnd());
      wait_idle(100, "m0 read");
      check("m0 read data", m0_data_o, DW'(5));
      check("m0 ack pulses", DW'(ack_cnt[0]), DW'(1));
      check("m1 ack pulses", DW'(ack_cnt[1]), DW'(0));
      force_delay = -1; force_rd_valid = 0;

      // ties after reset: m0 first, then m1; after a lone m0 grant the next tie goes to m1
      do_reset(2);
      ack_order.delete();
      issue(0, 0, 32'h100, rnd()); issue(1, 0, 32'h200, rnd());
      wait_idle(100, "tie 1");
      issue(0, 0, 32'h300, rnd());
      wait_idle(100, "single m0");
      issue(0, 0, 32'h500, rnd()); issue(1, 0, 32'h600, rnd());
      wait_idle(100, "tie 2");
      check("ack count ties", DW'(ack_order.size()), DW'(5));
      if (ack_order.size() == 5) begin
         check("tie1 first",  DW'(ack_order[0]), DW'(0));
         check("tie1 second", DW'(ack_order[1]), DW'(1));
         check("single",      DW'(ack_order[2]), DW'(0));
         check("tie2 first",  DW'(ack_order[3]), DW'(1));
         check("tie2 second", DW'(ack_order[4]), DW'(0));
      end

      // m1 write of all-ones to 0x400 leaves m1_data_o alone
      keep = d[1];
      force_delay = 4;
      issue(1, 1, 32'h400, '1);
      wait_idle(100, "m1 write");
      check("m1 data after write", m1_data_o, keep);
      force_delay = -1;

      // reset three cycles into BUSY: no ack, next request served normally
      force_delay = 50;
      issue(0, 0, 32'h40, rnd());
      a0 = 0;
      while (!m_busy && a0 < 10) begin step(); a0++; end
      repeat (3) step();
      a0 = ack_cnt[0];
      do_reset(2);
      repeat (3) step();
      check("no ack after reset", DW'(ack_cnt[0]), DW'(a0));
      force_delay = 2;
      issue(0, 0, 32'h80, rnd());
      wait_idle(100, "after reset");
      check("ack after reset", DW'(ack_cnt[0]), DW'(a0 + 1));
      force_delay = -1;

      // spurious memory acks while idle
      a0 = ack_cnt[0] + ack_cnt[1];
      keep = d[0];
      spur_en = 1;
      repeat (20) step();
      check("spurious acks", DW'(ack_cnt[0] + ack_cnt[1]), DW'(a0));
      check("spurious data", m0_data_o, keep);

      // randomized traffic
      auto_req = 1; drop_en = 1;
      repeat (3000) step();
      auto_req = 0;
      wait_idle(3000, "random drain");
      drop_en = 0; spur_en = 0;

      if (TO_ON) begin
         // memory never answers: watchdog ends BUSY after TO cycles with err
         keep = d[0];
         force_delay = 1000;
         repeat (2) step();
         en_cycles = 0; err_cnt = 0; a0 = ack_cnt[0];
         issue(0, 0, 32'hC0, rnd());
         wait_idle(100, "timeout");
         check("timeout busy cycles", DW'(en_cycles), DW'(TO));
         check("timeout err acks", DW'(err_cnt), DW'(1));
         check("timeout m0 ack", DW'(ack_cnt[0]), DW'(a0 + 1));
         check("timeout data", m0_data_o, keep);
         force_delay = -1;
      end

      repeat (2) step();
      check("mem_q empty", DW'(mem_q.size()), '0);
      check("resp_q empty", DW'(resp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 256, cache-line data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in BUSY (used only with MEM_ARB_TIMEOUT_EN).
REQ-004 SHALL have ports, clock and reset first; one clock, reset asynchronous active-low:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-low reset
- m0_enable_i  input  1  requester 0 (dcache) request
- m0_write_i  input  1  requester 0 write (1) / read (0)
- m0_addr_i  input  ADDR_W  requester 0 line address
- m0_data_i  input  DATA_W  requester 0 write data
- m0_ack_o  output  1  requester 0 completion pulse
- m0_data_o  output  DATA_W  requester 0 read data
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o  same as m0, requester 1 (icache)
- mem_enable_o  output  1  memory request
- mem_write_o  output  1  memory write
- mem_addr_o  output  ADDR_W  memory address
- mem_data_o  output  DATA_W  memory write data
- mem_ack_i  input  1  memory completion
- mem_data_i  input  DATA_W  memory read data
- err_o  output  1  timeout flag, qualifies mX_ack_o

Function
REQ-005 SHALL implement FSM with states IDLE, BUSY, RESP.
REQ-006 IDLE: if any mX_enable_i=1, SHALL capture winner's write/addr/data into registers, record owner, go to BUSY next edge; else stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: both requesting -> grant the requester not granted last; single request -> grant it regardless of history.
REQ-008 BUSY: mem_enable_o=1 with captured mem_write_o/mem_addr_o/mem_data_o held constant; on mem_ack_i=1, SHALL register mem_data_i into owner's mX_data_o and go to RESP.
REQ-009 RESP: mem_enable_o=0; owner's mX_ack_o=1 for exactly one cycle; next state IDLE.
REQ-010 Latency: grant edge to mem_enable_o=1 is 1 cycle; mem_ack_i sampled at edge N -> mX_ack_o high in cycle N+1.
REQ-011 Requester SHALL hold mX_enable_i until its ack and drop it in the following cycle; arbiter never acks a non-owner.
REQ-012 Requester dropping enable mid-BUSY SHALL NOT abort; transaction completes and ack is still issued.
REQ-013 mem_ack_i outside BUSY SHALL be ignored.
REQ-014 Non-owner mX_data_o SHALL retain previous value; write transactions SHALL NOT update mX_data_o.
REQ-015 Minimum spacing between successive grants SHALL be IDLE-BUSY-RESP (>=3 cycles); no back-to-back grant from RESP.

Reset
REQ-016 rst_i=0 SHALL immediately force IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, m0/m1_ack_o=0, m0/m1_data_o=0, err_o=0, last-grant=1 (m0 wins first tie).
REQ-017 Reset mid-BUSY SHALL discard the pending transaction with no ack.

Configuration
REQ-018 Macro MEM_ARB_TIMEOUT_EN defined: BUSY cycle counter, cleared on BUSY entry; reaching TIMEOUT_CYCLES without mem_ack_i SHALL drop mem_enable_o, go to RESP with err_o=1 alongside mX_ack_o; mX_data_o unchanged.
REQ-019 Macro not defined: no counter, BUSY waits indefinitely, err_o tied 0.

Verification
REQ-020 m0 read 0x00000000, memory acks after 10 cycles with data 0x5 -> one m0_ack_o pulse, m0_data_o=0x5, m1_ack_o never high.
REQ-021 m0 and m1 assert same cycle after reset -> m0 served first, then m1; next simultaneous pair -> m1 first.
REQ-022 m1 write addr 0x00000400 data all-ones -> mem_write_o=1, mem_addr_o=0x400, mem_data_o all-ones held for whole BUSY; m1_data_o unchanged.
REQ-023 rst_i low 3 cycles into BUSY -> all outputs 0 immediately, no ack; next request served normally.
REQ-024 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks -> mem_enable_o drops after 8 BUSY cycles, m0_ack_o=1 with err_o=1 one cycle.
REQ-025 Spurious mem_ack_i in IDLE -> no ack, no data change.
